// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums COUNT unsigned 16-bit products (from an upstream 8x8 multiplier) into
// one ACC_W-bit frame result, then holds that result until the downstream
// consumer takes it.
//
// Parameters:
//   COUNT  - products per frame (2..256)
//   ACC_W  - accumulator / sum width in bits (16..32)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   p          in   16-bit unsigned product
//   in_valid   in   p is valid this cycle
//   in_ready   out  block accepts p this cycle (ACCUM state)
//   clear      in   synchronous abort of the current frame
//   sum        out  frame result
//   out_valid  out  sum/overflow valid (HOLD state)
//   out_ready  in   downstream takes the result
//   overflow   out  frame result exceeded 2^ACC_W-1
//
// Build option:
//   ACC_SATURATE_EN - when defined, the accumulator clamps to 2^ACC_W-1 on
//                     carry-out and stays clamped for the rest of the frame.
//                     When undefined, the accumulator wraps modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module product_accumulator #(
   parameter int COUNT = 4,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      p,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             clear,
   output logic [ACC_W-1:0] sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow
);

   // cnt only has to reach COUNT-1, so clog2(COUNT) bits suffice (min 1).
   localparam int                CNT_W    = (COUNT > 2) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COUNT - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             state_q,    state_d;
   logic [ACC_W-1:0]   acc_q,      acc_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               ovf_q,      ovf_d;       // sticky carry of the frame in progress
   logic [ACC_W-1:0]   sum_q,      sum_d;
   logic               overflow_q, overflow_d;  // overflow of the held result

   logic               carry;
   logic [ACC_W-1:0]   add_raw;
   logic [ACC_W-1:0]   add_val;

   // Adder with explicit carry-out; p is zero-extended.
   always_comb begin
      {carry, add_raw} = {1'b0, acc_q} + (ACC_W + 1)'(p);
`ifdef ACC_SATURATE_EN
      // Once the frame has overflowed, keep the accumulator pinned at max.
      add_val = (ovf_q || carry) ? {ACC_W{1'b1}} : add_raw;
`else
      add_val = add_raw;
`endif
   end

   // Next-state and datapath.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      sum_d      = sum_q;
      overflow_d = overflow_q;

      if (clear) begin
         // Abort wins over accept and handshake; sum keeps its stale value.
         state_d    = ACCUM;
         acc_d      = '0;
         cnt_d      = '0;
         ovf_d      = 1'b0;
         overflow_d = 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  if (cnt_q == CNT_LAST) begin
                     // Last product: publish result and rearm for next frame.
                     sum_d      = add_val;
                     overflow_d = ovf_q | carry;
                     acc_d      = '0;
                     cnt_d      = '0;
                     ovf_d      = 1'b0;
                     state_d    = HOLD;
                  end else begin
                     acc_d = add_val;
                     cnt_d = cnt_q + 1'b1;
                     ovf_d = ovf_q | carry;
                  end
               end
            end
            HOLD: begin
               // in_valid is ignored here; the result stays until taken.
               if (out_ready) begin
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ACCUM;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         sum_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         sum_q      <= sum_d;
         overflow_q <= overflow_d;
      end
   end

   // Handshake outputs are decoded straight from the state register.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign sum       = sum_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Directed testbench. Instance dut_a uses the defaults (COUNT=4, ACC_W=24);
// instance dut_b uses COUNT=2, ACC_W=16 for the overflow scenario. Inputs are
// driven and outputs sampled on the falling edge, so every sample reflects the
// state after the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] p;
   logic        in_valid;
   logic        in_valid_b;
   logic        clear;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, overflow_a;
   logic [23:0] sum_a;
   logic        in_ready_b, out_valid_b, overflow_b;
   logic [15:0] sum_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   product_accumulator #(.COUNT(4), .ACC_W(24)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .p         (p),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .clear     (clear),
      .sum       (sum_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .overflow  (overflow_a)
   );

   product_accumulator #(.COUNT(2), .ACC_W(16)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .p         (p),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .clear     (clear),
      .sum       (sum_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .overflow  (overflow_b)
   );

   // Stimulus helpers (no checking inside).
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; clear = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Four consecutive accepts of val on dut_a; returns on the falling edge
   // after the 4th accept with in_valid low.
   task automatic run_frame(input logic [15:0] val);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         p = val; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; p = '0; in_valid = 1'b0; in_valid_b = 1'b0;
      clear = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
      checks++; if (sum_a !== 24'd0) begin failures++; $display("FAIL reset_sum: got %0d want 0", sum_a); end
      checks++; if (overflow_a !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow_a); end
      $display("test_reset: in_ready=%b out_valid=%b sum=%0d", in_ready_a, out_valid_a, sum_a);
   endtask

   task automatic test_basic_frame();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL basic_early_valid: accept %0d got %b want 0", i, out_valid_a); end
         end
         p = 16'd22; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL basic_out_valid: got %b want 1", out_valid_a); end
      checks++; if (sum_a !== 24'd88) begin failures++; $display("FAIL basic_sum: got %0d want 88", sum_a); end
      checks++; if (overflow_a !== 1'b0) begin failures++; $display("FAIL basic_overflow: got %b want 0", overflow_a); end
      checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL basic_in_ready_hold: got %b want 0", in_ready_a); end
      @(negedge clk);
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle: got %b want 0", out_valid_a); end
      checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL basic_in_ready_back: got %b want 1", in_ready_a); end
      $display("test_basic_frame: p=22 x4 sum=%0d overflow=%b", sum_a, overflow_a);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      run_frame(16'd22);
      // Offer a product during HOLD; it must not be consumed.
      p = 16'd999; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL bp_out_valid: cycle %0d got %b want 1", i, out_valid_a); end
         checks++; if (sum_a !== 24'd88) begin failures++; $display("FAIL bp_sum_held: cycle %0d got %0d want 88", i, sum_a); end
         checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", i, in_ready_a); end
         if (i < 4) @(negedge clk);
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL bp_release: got %b want 0", out_valid_a); end
      run_frame(16'd10);
      checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL bp_next_valid: got %b want 1", out_valid_a); end
      checks++; if (sum_a !== 24'd40) begin failures++; $display("FAIL bp_next_sum: got %0d want 40", sum_a); end
      @(negedge clk);
      $display("test_backpressure: held 88 for 5 cycles, next frame sum=40");
   endtask

   task automatic test_overflow();
      logic [15:0] exp_sum;
`ifdef ACC_SATURATE_EN
      exp_sum = 16'hFFFF;
`else
      exp_sum = 16'h0001;
`endif
      out_ready = 1'b1;
      checks++; if (in_ready_b !== 1'b1) begin failures++; $display("FAIL ovf_in_ready: got %b want 1", in_ready_b); end
      @(negedge clk); p = 16'hFFFF; in_valid_b = 1'b1;
      @(negedge clk); p = 16'h0002;
      @(negedge clk); in_valid_b = 1'b0;
      checks++; if (out_valid_b !== 1'b1) begin failures++; $display("FAIL ovf_out_valid: got %b want 1", out_valid_b); end
      checks++; if (sum_b !== exp_sum) begin failures++; $display("FAIL ovf_sum: got %h want %h", sum_b, exp_sum); end
      checks++; if (overflow_b !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow_b); end
      $display("test_overflow: FFFF+0002 sum=%h overflow=%b", sum_b, overflow_b);
      @(negedge clk); p = 16'd1; in_valid_b = 1'b1;
      @(negedge clk); p = 16'd1;
      @(negedge clk); in_valid_b = 1'b0;
      checks++; if (sum_b !== 16'd2) begin failures++; $display("FAIL ovf_next_sum: got %0d want 2", sum_b); end
      checks++; if (overflow_b !== 1'b0) begin failures++; $display("FAIL ovf_next_flag: got %b want 0", overflow_b); end
      @(negedge clk);
      $display("test_overflow: next frame 1+1 sum=%0d overflow=%b", sum_b, overflow_b);
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      @(negedge clk); p = 16'd100; in_valid = 1'b1;
      @(negedge clk); p = 16'd100;
      @(negedge clk); p = 16'd5; clear = 1'b1;
      @(negedge clk); clear = 1'b0; in_valid = 1'b0;
      checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL clear_in_ready: got %b want 1", in_ready_a); end
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL clear_out_valid: got %b want 0", out_valid_a); end
      run_frame(16'd3);
      checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL clear_frame_valid: got %b want 1", out_valid_a); end
      checks++; if (sum_a !== 24'd12) begin failures++; $display("FAIL clear_frame_sum: got %0d want 12", sum_a); end
      @(negedge clk);
      $display("test_clear: after clear, p=3 x4 sum=%0d", sum_a);
   endtask

   task automatic test_reset_in_hold();
      out_ready = 1'b0;
      run_frame(16'd22);
      checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL rsthold_pre_valid: got %b want 1", out_valid_a); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL rsthold_out_valid: got %b want 0", out_valid_a); end
      checks++; if (sum_a !== 24'd0) begin failures++; $display("FAIL rsthold_sum: got %0d want 0", sum_a); end
      checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL rsthold_in_ready: got %b want 1", in_ready_a); end
      $display("test_reset_in_hold: out_valid=%b sum=%0d in_ready=%b", out_valid_a, sum_a, in_ready_a);
   endtask

   task automatic test_gapped();
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL gap_early_valid: step %0d got %b want 0", i, out_valid_a); end
         end
         p = 16'd7; in_valid = (i % 2 == 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL gap_out_valid: got %b want 1", out_valid_a); end
      checks++; if (sum_a !== 24'd28) begin failures++; $display("FAIL gap_sum: got %0d want 28", sum_a); end
      @(negedge clk);
      $display("test_gapped: p=7 with gaps sum=%0d", sum_a);
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_overflow();
      do_reset();
      test_clear();
      test_reset_in_hold();
      test_gapped();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
